// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported data memory between the
// instruction-fetch (I) and load/store (D) requesters.
// The winning request is latched in IDLE. It drives the memory for one
// access (ACCESS, stretched by mem_stall). A one-cycle done pulse follows
// in DONE. One access completes every three cycles at most.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking.
// Without it, D has fixed priority over I.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_v,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              pick_port;
  logic              mem_v_q, mem_v_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;

  // Arbitration: a lone request always wins; ties follow the build option.
  always_comb begin
    pick_port = PORT_D;
    if (i_req && !d_req) begin
      pick_port = PORT_I;
    end else if (d_req && !i_req) begin
      pick_port = PORT_D;
    end else begin
`ifdef MEM_ARB_RR_EN
      pick_port = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
`else
      pick_port = PORT_D;
`endif
    end
  end

  // Next-state logic. Only IDLE looks at the requester inputs, so the
  // memory port is always driven from the latched copy.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_v_d      = mem_v_q;
    mem_we_d     = mem_we_q;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        mem_v_d = 1'b0;
        if (i_req || d_req) begin
          grant_d      = pick_port;
          last_grant_d = pick_port;
          mem_v_d      = 1'b1;
          state_d      = ACCESS;
          if (pick_port == PORT_D) begin
            mem_we_d    = d_we;
            mem_size_d  = d_size;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            // Fetches are always full-width reads.
            mem_we_d    = 1'b0;
            mem_size_d  = 2'b11;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // The store commits on this exit edge. The data read here is the
        // pre-store contents.
        if (!mem_stall) begin
          mem_v_d = 1'b0;
          state_d = DONE;
          if (grant_q == PORT_D) begin
            d_rdata_d = mem_rdata;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        mem_v_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        mem_v_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset clears everything, which also
  // aborts an in-flight access without a done pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= PORT_I;
      last_grant_q <= PORT_I;
      mem_v_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_size_q   <= 2'b00;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_v_q      <= mem_v_d;
      mem_we_q     <= mem_we_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_v     = mem_v_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It provides a byte-addressed memory
// (256 bytes, little-endian, wrapping) and a transaction-level reference
// model. The model tracks the expected winner, read data and memory image.
// It honours MEM_ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [63:0] i_addr = '0;
  logic        i_done;
  logic [63:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        mem_v;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_stall = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  env_mem [0:255];
  logic [7:0]  ref_mem [0:255];
  bit          sync_mem = 1'b0;
  int          write_count = 0;

  bit          ref_last = 1'b0;
  logic [63:0] ref_i_rdata = '0;
  logic [63:0] ref_d_rdata = '0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .CLK(CLK), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_v(mem_v), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Combinational read of 8 bytes starting at mem_addr.
  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 8; k++)
      mem_rdata[8*k +: 8] = env_mem[8'(mem_addr[7:0] + 8'(k))];
  end

  // Memory writes: bulk load from the reference image, or a committed store.
  always @(posedge CLK) begin
    if (sync_mem) begin
      for (int k = 0; k < 256; k++) env_mem[k] <= ref_mem[k];
    end else if (mem_v && mem_we && !mem_stall) begin
      for (int k = 0; k < (1 << mem_size); k++)
        env_mem[8'(mem_addr[7:0] + 8'(k))] <= mem_wdata[8*k +: 8];
      write_count <= write_count + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_pick(bit ir, bit dr);
    if (ir && !dr) return 1'b0;
    if (dr && !ir) return 1'b1;
`ifdef MEM_ARB_RR_EN
    return !ref_last;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] ref_read(logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[8'(a[7:0] + 8'(k))];
    return r;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    for (int k = 0; k < (1 << sz); k++) ref_mem[8'(a[7:0] + 8'(k))] = wd[8*k +: 8];
  endtask

  task automatic push_mem();
    sync_mem = 1'b1;
    @(posedge CLK); #1;
    sync_mem = 1'b0;
  endtask

  // One arbitrated access. Entered and left at #1 inside an IDLE cycle.
  task automatic do_txn(input bit ir, input bit dr, input logic [63:0] ia,
                        input logic [63:0] da, input bit we, input logic [1:0] sz,
                        input logic [63:0] wd, input int ns, input bit garble,
                        input bit hold_loser);
    bit          win_d;
    logic [63:0] ea, ewd, exp_rd;
    bit          ewe;
    logic [1:0]  esz;
    int          wc0, cyc;
    bit          seen;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = we; d_size = sz; d_addr = da; d_wdata = wd;
    mem_stall = (ns > 0);
    if (!ir && !dr) begin
      @(posedge CLK); #1;
      checks++;
      if (mem_v !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req: mem_v=%b busy=%b required 0 0", mem_v, busy);
      end
      return;
    end
    win_d = model_pick(ir, dr);
    ref_last = win_d;
    ea  = win_d ? da : ia;
    ewe = win_d ? we : 1'b0;
    esz = win_d ? sz : 2'b11;
    ewd = win_d ? wd : 64'h0;
    exp_rd = ref_read(ea);
    if (ewe) ref_write(ea, esz, ewd);
    if (win_d) ref_d_rdata = exp_rd; else ref_i_rdata = exp_rd;
    wc0 = write_count;

    @(posedge CLK); #1;
    checks++;
    if (mem_v !== 1'b1 || busy !== 1'b1 || mem_addr !== ea || mem_we !== ewe ||
        mem_size !== esz || mem_wdata !== ewd) begin
      errors++;
      $display("FAIL grant_port: v=%b busy=%b addr=%h we=%b size=%b wdata=%h required 1 1 %h %b %b %h",
               mem_v, busy, mem_addr, mem_we, mem_size, mem_wdata, ea, ewe, esz, ewd);
    end

    cyc = 0; seen = 1'b0;
    while (cyc < ns + 8 && !seen) begin
      if (garble) begin
        i_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom}; d_we = 1'($urandom); d_size = 2'($urandom);
      end
      if (cyc >= ns) mem_stall = 1'b0;
      @(posedge CLK); #1;
      cyc++;
      if (i_done || d_done) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (mem_v !== 1'b1 || mem_addr !== ea || mem_we !== ewe || mem_size !== esz ||
            mem_wdata !== ewd) begin
          errors++;
          $display("FAIL access_hold: cyc=%0d v=%b addr=%h we=%b size=%b required 1 %h %b %b",
                   cyc, mem_v, mem_addr, mem_we, mem_size, ea, ewe, esz);
        end
      end
    end

    checks++;
    if (!seen || cyc != ns + 1) begin
      errors++;
      $display("FAIL latency: done seen=%b after %0d cycles required %0d", seen, cyc, ns + 1);
    end
    checks++;
    if (i_done !== !win_d || d_done !== win_d || mem_v !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: i_done=%b d_done=%b mem_v=%b busy=%b required %b %b 0 1",
               i_done, d_done, mem_v, busy, !win_d, win_d);
    end
    checks++;
    if (i_rdata !== ref_i_rdata || d_rdata !== ref_d_rdata) begin
      errors++;
      $display("FAIL rdata: i_rdata=%h d_rdata=%h required %h %h",
               i_rdata, d_rdata, ref_i_rdata, ref_d_rdata);
    end
    checks++;
    if (write_count - wc0 !== (ewe ? 1 : 0)) begin
      errors++;
      $display("FAIL write_count: got %0d writes required %0d", write_count - wc0, ewe ? 1 : 0);
    end

    if (win_d) d_req = 1'b0; else i_req = 1'b0;
    if (!hold_loser) begin i_req = 1'b0; d_req = 1'b0; end
    @(posedge CLK); #1;
    checks++;
    if (busy !== 1'b0 || mem_v !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b mem_v=%b i_done=%b d_done=%b required 0 0 0 0",
               busy, mem_v, i_done, d_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({i_done, d_done, mem_v, mem_we, busy} !== 5'b0 || mem_size !== 2'b0 ||
        mem_addr !== 64'h0 || mem_wdata !== 64'h0 || i_rdata !== 64'h0 || d_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b size=%b addr=%h wdata=%h ird=%h drd=%h required all zero",
               {i_done, d_done, mem_v, mem_we, busy}, mem_size, mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    reset = 1'b0;
    ref_last = 1'b0; ref_i_rdata = '0; ref_d_rdata = '0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'($urandom);
    push_mem();
    checks++;
    if (busy !== 1'b0 || mem_v !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b mem_v=%b required 0 0", busy, mem_v);
    end
  endtask

  task automatic test_fetch();
    logic [63:0] v;
    v = 64'h1122334455667788;
    for (int k = 0; k < 8; k++) ref_mem[8 + k] = v[8*k +: 8];
    push_mem();
    do_txn(1, 0, 64'h8, 64'h0, 0, 2'b00, 64'h0, 0, 0, 0);
    checks++;
    if (i_rdata !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL fetch_data: i_rdata=%h required 1122334455667788", i_rdata);
    end
  endtask

  task automatic test_store_load();
    logic [63:0] v;
    v = 64'h0102030405060708;
    for (int k = 0; k < 8; k++) ref_mem[k] = v[8*k +: 8];
    push_mem();
    do_txn(0, 1, 64'h0, 64'h0, 1, 2'b10, 64'hDEADBEEF, 0, 0, 0);
    checks++;
    if (d_rdata !== 64'h0102030405060708) begin
      errors++;
      $display("FAIL store_prestore: d_rdata=%h required 0102030405060708", d_rdata);
    end
    do_txn(0, 1, 64'h0, 64'h0, 0, 2'b11, 64'h0, 0, 0, 0);
    checks++;
    if (d_rdata !== 64'h01020304DEADBEEF) begin
      errors++;
      $display("FAIL load_after_store: d_rdata=%h required 01020304deadbeef", d_rdata);
    end
  endtask

  task automatic test_tie();
    for (int n = 0; n < 4; n++)
      do_txn(1, 1, 64'h40 + 64'(8 * n), 64'h80 + 64'(8 * n), 0, 2'b11, 64'h0, 0, 0, 1);
    for (int n = 0; n < 4; n++)
      do_txn(1, (n % 2) == 0, 64'h20, 64'h28, 0, 2'b01, 64'h0, 0, 0, 1);
  endtask

  task automatic test_stall();
    do_txn(0, 1, 64'h30, 64'h30, 1, 2'b11, 64'hCAFEF00D12345678, 3, 0, 0);
    do_txn(1, 0, 64'h30, 64'h0, 0, 2'b00, 64'h0, 2, 0, 0);
  endtask

  task automatic test_reset_abort();
    int wc0;
    wc0 = write_count;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b11; d_addr = 64'h50; d_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_stall = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (mem_v !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: mem_v=%b busy=%b required 1 1", mem_v, busy);
    end
    reset = 1'b1; d_req = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (mem_v !== 1'b0 || busy !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0 ||
        i_rdata !== 64'h0 || d_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_abort: v=%b busy=%b done=%b%b ird=%h drd=%h required 0 0 00 0 0",
               mem_v, busy, i_done, d_done, i_rdata, d_rdata);
    end
    reset = 1'b0; mem_stall = 1'b0;
    ref_last = 1'b0; ref_i_rdata = '0; ref_d_rdata = '0;
    for (int n = 0; n < 4; n++) begin
      @(posedge CLK); #1;
      checks++;
      if (i_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b0 || write_count != wc0) begin
        errors++;
        $display("FAIL abort_quiet: done=%b%b busy=%b writes=%0d required 00 0 %0d",
                 i_done, d_done, busy, write_count, wc0);
      end
    end
    do_txn(1, 1, 64'h60, 64'h68, 0, 2'b11, 64'h0, 0, 0, 0);
  endtask

  task automatic test_addr_change();
    do_txn(0, 1, 64'h0, 64'h90, 1, 2'b01, 64'h0000_0000_0000_ABCD, 2, 1, 0);
    do_txn(0, 1, 64'h0, 64'h90, 0, 2'b11, 64'h0, 1, 1, 0);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 4);
      do_txn(r == 0 || r == 2, r == 1 || r == 2 || r == 3,
             {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom),
             {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom), 0);
    end
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (env_mem[k] !== ref_mem[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mem_image: %0d bytes differ, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_stall();
    test_reset_abort();
    test_addr_change();
    test_random();
    test_mem_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
